// File: rtl/queue_drain_if.sv
// Pop-side FIFO link plus consumer valid/ready link for queue_drain.
// The master modport is the drain controller; slave is the FIFO/consumer side.
interface queue_drain_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  qEmpty_IN;
   logic [DATA_WIDTH-1:0] qData_IN;
   logic                  qPopValid_IN;
   logic                  qPopReq_OUT;
   logic                  outValid_OUT;
   logic [DATA_WIDTH-1:0] outData_OUT;
   logic                  outReady_IN;
   logic [CNT_WIDTH-1:0]  popCount_OUT;
   logic                  protoErr_OUT;

   modport master (
      input  qEmpty_IN, qData_IN, qPopValid_IN, outReady_IN,
      output qPopReq_OUT, outValid_OUT, outData_OUT, popCount_OUT, protoErr_OUT
   );

   modport slave (
      output qEmpty_IN, qData_IN, qPopValid_IN, outReady_IN,
      input  qPopReq_OUT, outValid_OUT, outData_OUT, popCount_OUT, protoErr_OUT
   );
endinterface

// File: rtl/queue_drain.sv
// Pop controller for a FIFO with one-cycle registered pop latency: credit-based
// pop issue, 2-entry skid buffer, delivered-word counter and sticky protocol flag.
module queue_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic          clk,
   input  logic          reset,
   queue_drain_if.master bus
);
   logic [DATA_WIDTH-1:0] skid_q [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;
   logic                  proto_err_q, proto_err_d;

   logic                  deq;
   logic                  arrival;
   logic                  pop_req;
   logic [1:0]            credit;

   always_comb begin
      deq     = (occ_q != 2'd0) && bus.outReady_IN;
      // Words held plus words owed by the FIFO, net of this cycle's dequeue;
      // the dequeue term is what lets a pop issue every cycle at full rate.
      credit  = occ_q + {1'b0, inflight_q} - {1'b0, deq};
      pop_req = !reset && !bus.qEmpty_IN && (credit < 2'd2);
      arrival = bus.qPopValid_IN && inflight_q;

      rd_ptr_d    = rd_ptr_q ^ deq;
      wr_ptr_d    = wr_ptr_q ^ arrival;
      occ_d       = occ_q + {1'b0, arrival} - {1'b0, deq};
      inflight_d  = pop_req;
      pop_count_d = deq ? pop_count_q + 1'b1 : pop_count_q;
      proto_err_d = proto_err_q || (bus.qPopValid_IN != inflight_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         occ_q       <= 2'd0;
         inflight_q  <= 1'b0;
         pop_count_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         occ_q       <= occ_d;
         inflight_q  <= inflight_d;
         pop_count_q <= pop_count_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Skid storage carries no reset; unsolicited words never reach it.
   always_ff @(posedge clk) begin
      if (!reset && arrival) begin
         skid_q[wr_ptr_q] <= bus.qData_IN;
      end
   end

   assign bus.qPopReq_OUT  = pop_req;
   assign bus.outValid_OUT = (occ_q != 2'd0);
   assign bus.outData_OUT  = skid_q[rd_ptr_q];
   assign bus.popCount_OUT = pop_count_q;
   assign bus.protoErr_OUT = proto_err_q;
endmodule
